// File: rtl/pos_pi_controller.sv
// Sequential sign-magnitude proportional pose controller with dwell-qualified goal detection.
// Optional integral path enabled by defining POS_PI_CONTROLLER_INTEGRAL_EN.
module pos_pi_controller #(
  parameter int                 N_WIDTH    = 17,
  parameter int                 Q_WIDTH    = 8,
  parameter logic [N_WIDTH-1:0] KP         = 17'h00080,
  parameter logic [N_WIDTH-1:0] VMAX       = 17'h00100,
  parameter logic [N_WIDTH-1:0] TOL_XY     = 17'h00010,
  parameter logic [N_WIDTH-1:0] TOL_TH     = 17'h00010,
  parameter int                 GOAL_DWELL = 3
) (
  input  logic               POS_PI_CONTROLLER_CLOCK_50,
  input  logic               POS_PI_CONTROLLER_RESET_InLow,
  input  logic               POS_PI_CONTROLLER_START_InHigh,
  input  logic [N_WIDTH-1:0] POS_PI_CONTROLLER_TARGETX_InBus,
  input  logic [N_WIDTH-1:0] POS_PI_CONTROLLER_TARGETY_InBus,
  input  logic [N_WIDTH-1:0] POS_PI_CONTROLLER_TARGETTHETA_InBus,
  input  logic [N_WIDTH-1:0] POS_PI_CONTROLLER_CURRENTX_InBus,
  input  logic [N_WIDTH-1:0] POS_PI_CONTROLLER_CURRENTY_InBus,
  input  logic [N_WIDTH-1:0] POS_PI_CONTROLLER_CURRENTTHETA_InBus,
  output logic               POS_PI_CONTROLLER_BUSY_OutHigh,
  output logic               POS_PI_CONTROLLER_DONE_OutHigh,
  output logic               POS_PI_CONTROLLER_GOAL_OutLow,
  output logic [N_WIDTH-1:0] POS_PI_CONTROLLER_ERROR_X_OutBus,
  output logic [N_WIDTH-1:0] POS_PI_CONTROLLER_ERROR_Y_OutBus,
  output logic [N_WIDTH-1:0] POS_PI_CONTROLLER_VX_OutBus,
  output logic [N_WIDTH-1:0] POS_PI_CONTROLLER_VY_OutBus,
  output logic [N_WIDTH-1:0] POS_PI_CONTROLLER_WZ_OutBus
);

  localparam int         MSB   = N_WIDTH - 1;
  localparam int         MAGW  = N_WIDTH - 1;
  localparam logic [7:0] DWELL = 8'(GOAL_DWELL);

  typedef logic [N_WIDTH-1:0] smWord;
  typedef logic [MAGW-1:0]    smMag;

  typedef enum logic [2:0] {
    IDLE,
    SUB,
    MUL,
    SAT,
`ifdef POS_PI_CONTROLLER_INTEGRAL_EN
    INTEG,
`endif
    UPD
  } stateT;

  logic  clk, rstN, start;
  stateT state, stateNext;
  smWord tgtX, tgtY, tgtTh, curX, curY, curTh;
  smWord errX, errY, errTh;
  smWord velX, velY, velZ;
  smWord errXOut, errYOut, vxOut, vyOut, wzOut;
  logic  doneReg, busy, inTol, goalNext;
  logic [7:0] dwellCnt, dwellNext;

  assign clk   = POS_PI_CONTROLLER_CLOCK_50;
  assign rstN  = POS_PI_CONTROLLER_RESET_InLow;
  assign start = POS_PI_CONTROLLER_START_InHigh;

  // Magnitudes add when signs agree (clamping on carry), otherwise the larger one wins the sign.
  function automatic smWord smAdd(input smWord a, input smWord b);
    logic [N_WIDTH-1:0] sum;
    smMag mag;
    logic sgn;
    sum = {1'b0, a[MAGW-1:0]} + {1'b0, b[MAGW-1:0]};
    if (a[MSB] == b[MSB]) begin
      mag = sum[MSB] ? '1 : sum[MAGW-1:0];
      sgn = a[MSB];
    end else if (a[MAGW-1:0] >= b[MAGW-1:0]) begin
      mag = a[MAGW-1:0] - b[MAGW-1:0];
      sgn = a[MSB];
    end else begin
      mag = b[MAGW-1:0] - a[MAGW-1:0];
      sgn = b[MSB];
    end
    if (mag == '0) sgn = 1'b0;
    return {sgn, mag};
  endfunction

  function automatic smWord smNeg(input smWord a);
    return {~a[MSB], a[MAGW-1:0]};
  endfunction

  function automatic smWord smMul(input smWord e);
    logic [2*N_WIDTH-1:0] prod;
    smMag mag;
    prod = {{(N_WIDTH+1){1'b0}}, e[MAGW-1:0]} * {{(N_WIDTH+1){1'b0}}, KP[MAGW-1:0]};
    mag  = (|prod[2*N_WIDTH-1:MAGW+Q_WIDTH]) ? '1 : prod[MAGW-1+Q_WIDTH:Q_WIDTH];
    return {e[MSB] ^ KP[MSB], mag};
  endfunction

  function automatic smWord smSat(input smWord v);
    if (v[MAGW-1:0] > VMAX[MAGW-1:0]) return {v[MSB], VMAX[MAGW-1:0]};
    if (v[MAGW-1:0] == '0)            return '0;
    return v;
  endfunction

`ifdef POS_PI_CONTROLLER_INTEGRAL_EN
  smWord accX, accY, accZ, accXNext, accYNext, accZNext;

  // Arithmetic shift of a sign-magnitude word: shift the magnitude, keep the sign.
  function automatic smWord smShr4(input smWord a);
    return {a[MSB], a[MAGW-1:0] >> 4};
  endfunction

  assign accXNext = smSat(smAdd(accX, errX));
  assign accYNext = smSat(smAdd(accY, errY));
  assign accZNext = smSat(smAdd(accZ, errTh));
`endif

  assign inTol = (errX[MAGW-1:0]  <= TOL_XY[MAGW-1:0]) &&
                 (errY[MAGW-1:0]  <= TOL_XY[MAGW-1:0]) &&
                 (errTh[MAGW-1:0] <= TOL_TH[MAGW-1:0]);
  assign dwellNext = !inTol ? 8'd0 : (dwellCnt == DWELL) ? dwellCnt : dwellCnt + 8'd1;
  assign goalNext  = (dwellNext == DWELL);

  always_ff @(posedge clk or negedge rstN) begin
    // NOTE: sequential state always uses <= so every register sees pre-edge values.
    if (!rstN) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    stateNext = state;
    busy      = (state != IDLE);
    unique case (state)
      IDLE:  if (start) stateNext = SUB;
      SUB:   stateNext = MUL;
      MUL:   stateNext = SAT;
`ifdef POS_PI_CONTROLLER_INTEGRAL_EN
      SAT:   stateNext = INTEG;
      INTEG: stateNext = UPD;
`else
      SAT:   stateNext = UPD;
`endif
      UPD:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    // NOTE: pipeline registers are reset as well, so an aborted computation leaves nothing behind.
    if (!rstN) begin
      {tgtX, tgtY, tgtTh, curX, curY, curTh} <= '0;
      {errX, errY, errTh, velX, velY, velZ}   <= '0;
      {errXOut, errYOut, vxOut, vyOut, wzOut} <= '0;
      dwellCnt <= '0;
      doneReg  <= 1'b0;
`ifdef POS_PI_CONTROLLER_INTEGRAL_EN
      {accX, accY, accZ} <= '0;
`endif
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: if (start) begin
          tgtX  <= POS_PI_CONTROLLER_TARGETX_InBus;
          tgtY  <= POS_PI_CONTROLLER_TARGETY_InBus;
          tgtTh <= POS_PI_CONTROLLER_TARGETTHETA_InBus;
          curX  <= POS_PI_CONTROLLER_CURRENTX_InBus;
          curY  <= POS_PI_CONTROLLER_CURRENTY_InBus;
          curTh <= POS_PI_CONTROLLER_CURRENTTHETA_InBus;
        end
        SUB: begin
          errX  <= smAdd(tgtX,  smNeg(curX));
          errY  <= smAdd(tgtY,  smNeg(curY));
          errTh <= smAdd(tgtTh, smNeg(curTh));
        end
        MUL: begin
          velX <= smMul(errX);
          velY <= smMul(errY);
          velZ <= smMul(errTh);
        end
        SAT: begin
          velX <= smSat(velX);
          velY <= smSat(velY);
          velZ <= smSat(velZ);
        end
`ifdef POS_PI_CONTROLLER_INTEGRAL_EN
        INTEG: begin
          accX <= accXNext;
          accY <= accYNext;
          accZ <= accZNext;
          velX <= smSat(smAdd(velX, smShr4(accXNext)));
          velY <= smSat(smAdd(velY, smShr4(accYNext)));
          velZ <= smSat(smAdd(velZ, smShr4(accZNext)));
        end
`endif
        UPD: begin
          errXOut  <= errX;
          errYOut  <= errY;
          dwellCnt <= dwellNext;
          vxOut    <= goalNext ? '0 : velX;
          vyOut    <= goalNext ? '0 : velY;
          wzOut    <= goalNext ? '0 : velZ;
          doneReg  <= 1'b1;
`ifdef POS_PI_CONTROLLER_INTEGRAL_EN
          if (goalNext) {accX, accY, accZ} <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign POS_PI_CONTROLLER_BUSY_OutHigh    = busy;
  assign POS_PI_CONTROLLER_DONE_OutHigh    = doneReg;
  assign POS_PI_CONTROLLER_GOAL_OutLow     = (dwellCnt != DWELL);
  assign POS_PI_CONTROLLER_ERROR_X_OutBus  = errXOut;
  assign POS_PI_CONTROLLER_ERROR_Y_OutBus  = errYOut;
  assign POS_PI_CONTROLLER_VX_OutBus       = vxOut;
  assign POS_PI_CONTROLLER_VY_OutBus       = vyOut;
  assign POS_PI_CONTROLLER_WZ_OutBus       = wzOut;

endmodule

// File: tb/tb_pos_pi_controller.sv
// Self-checking bench for pos_pi_controller (proportional build): directed plan cases plus
// randomized poses compared against an integer-arithmetic reference model.
module tb_pos_pi_controller;

  localparam int KP_MAG   = 128;
  localparam int VMAX_MAG = 256;
  localparam int TOL_MAG  = 16;
  localparam int DWELL    = 3;
  localparam int FRAC     = 8;

  typedef struct {
    logic [16:0] ex, ey, vx, vy, wz;
    logic        goalN;
  } expT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, start;
  logic [16:0] tX, tY, tTh, cX, cY, cTh;
  logic        busy, done, goalN;
  logic [16:0] errX, errY, vx, vy, wz;

  int nTests = 0;
  int nFail = 0;
  int modelCnt = 0;
  int doneCount = 0;

  pos_pi_controller dut (
    .POS_PI_CONTROLLER_CLOCK_50           (clk),
    .POS_PI_CONTROLLER_RESET_InLow        (rstN),
    .POS_PI_CONTROLLER_START_InHigh       (start),
    .POS_PI_CONTROLLER_TARGETX_InBus      (tX),
    .POS_PI_CONTROLLER_TARGETY_InBus      (tY),
    .POS_PI_CONTROLLER_TARGETTHETA_InBus  (tTh),
    .POS_PI_CONTROLLER_CURRENTX_InBus     (cX),
    .POS_PI_CONTROLLER_CURRENTY_InBus     (cY),
    .POS_PI_CONTROLLER_CURRENTTHETA_InBus (cTh),
    .POS_PI_CONTROLLER_BUSY_OutHigh       (busy),
    .POS_PI_CONTROLLER_DONE_OutHigh       (done),
    .POS_PI_CONTROLLER_GOAL_OutLow        (goalN),
    .POS_PI_CONTROLLER_ERROR_X_OutBus     (errX),
    .POS_PI_CONTROLLER_ERROR_Y_OutBus     (errY),
    .POS_PI_CONTROLLER_VX_OutBus          (vx),
    .POS_PI_CONTROLLER_VY_OutBus          (vy),
    .POS_PI_CONTROLLER_WZ_OutBus          (wz)
  );

  always @(negedge clk) if (done === 1'b1) doneCount++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int smToInt(input logic [16:0] v);
    int m;
    m = int'(v[15:0]);
    return v[16] ? -m : m;
  endfunction

  function automatic logic [16:0] intToSm(input int v);
    int m;
    m = (v < 0) ? -v : v;
    if (m > 65535) m = 65535;
    if (m == 0) return 17'h0;
    return {(v < 0), m[15:0]};
  endfunction

  // Velocity = error * KP in real-number terms, truncated, then limited to VMAX.
  function automatic logic [16:0] velocity(input logic [16:0] err);
    int m;
    m = (int'(err[15:0]) * KP_MAG) / (1 << FRAC);
    if (m > 65535) m = 65535;
    if (m > VMAX_MAG) m = VMAX_MAG;
    return intToSm(err[16] ? -m : m);
  endfunction

  task automatic predict(output expT e);
    logic [16:0] sx, sy, sth;
    logic        tol;
    sx  = intToSm(smToInt(tX)  - smToInt(cX));
    sy  = intToSm(smToInt(tY)  - smToInt(cY));
    sth = intToSm(smToInt(tTh) - smToInt(cTh));
    tol = (int'(sx[15:0]) <= TOL_MAG) && (int'(sy[15:0]) <= TOL_MAG) && (int'(sth[15:0]) <= TOL_MAG);
    modelCnt = tol ? ((modelCnt < DWELL) ? modelCnt + 1 : DWELL) : 0;
    e.goalN = (modelCnt != DWELL);
    e.ex = sx;
    e.ey = sy;
    e.vx = e.goalN ? velocity(sx)  : 17'h0;
    e.vy = e.goalN ? velocity(sy)  : 17'h0;
    e.wz = e.goalN ? velocity(sth) : 17'h0;
  endtask

  task automatic setPose(input logic [16:0] a, b, c, d, f, g);
    tX = a; tY = b; tTh = c; cX = d; cY = f; cTh = g;
  endtask

  task automatic runSample(input string name);
    expT e;
    int cyc;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy"}, busy, 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_latency"}, cyc, 4);
    predict(e);
    check({name, "_busy_done"}, busy, 0);
    check({name, "_errx"}, errX, e.ex);
    check({name, "_erry"}, errY, e.ey);
    check({name, "_vx"}, vx, e.vx);
    check({name, "_vy"}, vy, e.vy);
    check({name, "_wz"}, wz, e.wz);
    check({name, "_goal"}, goalN, e.goalN);
    @(posedge clk); #1;
    check({name, "_done_one_cycle"}, done, 0);
    check({name, "_vx_stable"}, vx, e.vx);
  endtask

  function automatic logic [16:0] rndSmall();
    return {1'($urandom_range(0, 1)), 16'($urandom_range(0, 24))};
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int snap, nDone, mode;
    expT e;
    rstN = 1'b0;
    start = 1'b0;
    setPose(17'h00200, 0, 0, 17'h00080, 0, 0);

    // Reset held with START toggling
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = ~start;
    end
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done_count", doneCount, 0);
    check("rst_goal", goalN, 1);
    check("rst_errx", errX, 0);
    check("rst_erry", errY, 0);
    check("rst_vx", vx, 0);
    check("rst_vy", vy, 0);
    check("rst_wz", wz, 0);
    start = 1'b0;
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Directed plan cases
    setPose(17'h00200, 0, 0, 17'h00080, 0, 0);
    runSample("planx");
    check("planx_errx_const", errX, 17'h00180);
    check("planx_vx_const", vx, 17'h000C0);
    check("planx_vy_const", vy, 17'h0);

    setPose(0, 0, 0, 0, 17'h00300, 0);
    runSample("plany");
    check("plany_erry_const", errY, 17'h10300);
    check("plany_vy_const", vy, 17'h10100);

    setPose(17'h00008, 17'h00008, 17'h00008, 0, 0, 0);
    runSample("dwell1");
    check("dwell1_goal_const", goalN, 1);
    runSample("dwell2");
    check("dwell2_goal_const", goalN, 1);
    runSample("dwell3");
    check("dwell3_goal_const", goalN, 0);
    check("dwell3_vx_const", vx, 0);
    setPose(17'h00020, 17'h00020, 17'h00020, 0, 0, 0);
    runSample("dwell4");
    check("dwell4_goal_const", goalN, 1);

    // Randomized poses
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 3);
      if (mode < 2) setPose(17'($urandom()), 17'($urandom()), 17'($urandom()),
                            17'($urandom()), 17'($urandom()), 17'($urandom()));
      else setPose(rndSmall(), rndSmall(), rndSmall(), rndSmall(), rndSmall(), rndSmall());
      if (mode == 3) begin cX = tX; cY = tY; cTh = tTh; end
      runSample("rand");
    end

    // START held high: DONE exactly every fifth cycle
    setPose(17'h00200, 0, 0, 17'h00080, 0, 0);
    nDone = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        nDone++;
        check("hold_phase", k % 5, 0);
      end
    end
    start = 1'b0;
    check("hold_count", nDone, 5);
    predict(e);
    check("hold_vx", vx, e.vx);
    repeat (2) @(negedge clk);

    // Reset in the middle of a computation
    setPose(17'h00008, 17'h00008, 17'h00008, 0, 0, 0);
    runSample("pre1");
    runSample("pre2");
    runSample("pre3");
    setPose(17'h00200, 17'h00200, 0, 0, 0, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rstN = 1'b0;
    modelCnt = 0;
    #1;
    snap = doneCount;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_goal", goalN, 1);
    check("midrst_errx", errX, 0);
    check("midrst_vx", vx, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_done", doneCount, snap);
    setPose(17'h00008, 17'h00008, 17'h00008, 0, 0, 0);
    runSample("post_tol");
    check("post_tol_goal_const", goalN, 1);
    setPose(17'h00200, 0, 0, 17'h00080, 0, 0);
    runSample("post_x");
    check("post_x_vx_const", vx, 17'h000C0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
